// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared seven-segment definitions: segment bit positions and the hex glyph table.
// Patterns are active-high, bit0 = a .. bit6 = g.
package seven_seg_scan_driver_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seven_seg_decode
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot,
// 16-level PWM dimming and a blanking window at each digit change.
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DIV_BITS       = 16,
    parameter int unsigned BLANK_CYCLES   = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   values,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_tick
);

    localparam int unsigned         IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_BITS-1:0] BLANK_END = DIV_BITS'(BLANK_CYCLES);
    localparam logic [6:0]          SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0]   SEL_OFF   = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [DIV_BITS-1:0] cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] values_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   digit_en_sh;
    logic [3:0]          brightness_sh;

    logic                slot_end;
    logic                frame_end;
    logic                lit;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_segs;
    logic [DIGITS-1:0]   cur_onehot;

    assign slot_end  = &cnt;
    assign frame_end = slot_end && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            values_sh     <= '0;
            dp_sh         <= '0;
            digit_en_sh   <= '0;
            brightness_sh <= '0;
            frame_tick    <= 1'b0;
        end else begin
            cnt        <= cnt + DIV_BITS'(1);
            frame_tick <= frame_end;
            if (slot_end) begin
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end
            // Inputs are only sampled here so a frame never mixes old and new data.
            if (frame_end) begin
                values_sh     <= values;
                dp_sh         <= dp;
                digit_en_sh   <= digit_en;
                brightness_sh <= brightness;
            end
        end
    end

    always_comb begin
        cur_onehot      = '0;
        cur_onehot[idx] = 1'b1;
        cur_nibble      = values_sh[{idx, 2'b00} +: 4];
        lit             = (cnt >= BLANK_END)
                       && digit_en_sh[idx]
                       && (cnt[DIV_BITS-1 -: 4] <= brightness_sh);
    end

    seven_seg_decode u_decode (
        .nibble (cur_nibble),
        .segs   (cur_segs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            seg_dp <= DP_OFF;
            sel    <= SEL_OFF;
        end else if (lit) begin
            seg    <= SEG_ACTIVE_LOW ? ~cur_segs : cur_segs;
            seg_dp <= SEG_ACTIVE_LOW ? ~dp_sh[idx] : dp_sh[idx];
            sel    <= SEL_ACTIVE_LOW ? ~cur_onehot : cur_onehot;
        end else begin
            seg    <= SEG_OFF;
            seg_dp <= DP_OFF;
            sel    <= SEL_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, 64-cycle slots, 2 blank cycles).
module tb_seven_seg_scan_driver;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk;
    logic        rst_n;
    logic [15:0] values;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  sel;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: n counts clock edges since reset release.
    int          n;
    int          m_cnt;
    int          m_idx;
    bit          m_lit;
    logic [3:0]  m_vals [4];
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic [3:0]  m_bright;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_sel;
    logic        exp_tick;

    seven_seg_scan_driver #(
        .DIGITS         (4),
        .DIV_BITS       (6),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .values     (values),
        .dp         (dp),
        .digit_en   (digit_en),
        .brightness (brightness),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic model_reset();
        n        = 0;
        m_dp     = '0;
        m_en     = '0;
        m_bright = '0;
        for (int i = 0; i < 4; i++) m_vals[i] = '0;
    endtask

    // Advance one edge; outputs after edge n show the state that held before it (n-1).
    task automatic step();
        int s;
        @(posedge clk);
        #1;
        n++;
        s        = n - 1;
        m_cnt    = s % 64;
        m_idx    = (s / 64) % 4;
        m_lit    = (m_cnt >= 2) && m_en[m_idx] && ((m_cnt / 4) <= int'(m_bright));
        exp_sel  = m_lit ? ~(4'b0001 << m_idx) : 4'hF;
        exp_seg  = m_lit ? ~HEX[m_vals[m_idx]] : 7'h7F;
        exp_dp   = m_lit ? ~m_dp[m_idx] : 1'b1;
        exp_tick = (n % 256 == 0);
        if (n % 256 == 0) begin
            for (int i = 0; i < 4; i++) m_vals[i] = values[4*i +: 4];
            m_dp     = dp;
            m_en     = digit_en;
            m_bright = brightness;
        end
    endtask

    task automatic sync_frame();
        step();
        for (int k = 0; k < 300 && (n % 256 != 0); k++) step();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        values     = '0;
        dp         = '0;
        digit_en   = '0;
        brightness = '0;
        model_reset();
        #22;
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++; if (seg_dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", seg_dp); end
        checks++; if (sel !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=f", sel); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame();
        values = 16'h1234; digit_en = 4'hF; brightness = 4'd15; dp = 4'h0;
        for (int k = 0; k < 512; k++) begin
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL first_frame n=%0d got seg=%h dp=%b sel=%h tick=%b exp seg=%h dp=%b sel=%h tick=%b",
                         n, seg, seg_dp, sel, frame_tick, exp_seg, exp_dp, exp_sel, exp_tick);
            end
            if (n == 259) begin
                checks++;
                if (seg !== 7'h19 || sel !== 4'hE) begin
                    errors++;
                    $display("FAIL first_digit0 got seg=%h sel=%h exp seg=19 sel=e", seg, sel);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] prev_sel;
        int         blank_run;
        values = 16'($urandom); digit_en = 4'hF; brightness = 4'd15;
        prev_sel  = sel;
        blank_run = 0;
        for (int k = 0; k < 512; k++) begin
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL blanking n=%0d got seg=%h dp=%b sel=%h tick=%b exp seg=%h dp=%b sel=%h tick=%b",
                         n, seg, seg_dp, sel, frame_tick, exp_seg, exp_dp, exp_sel, exp_tick);
            end
            checks++;
            if ($countones(~sel) > 1) begin
                errors++;
                $display("FAIL multi_sel n=%0d got sel=%h exp at most one low bit", n, sel);
            end
            if (sel == 4'hF) blank_run++;
            else begin
                if (prev_sel == 4'hF) begin
                    checks++;
                    if (blank_run != 2) begin
                        errors++;
                        $display("FAIL blank_window n=%0d got %0d blank cycles exp 2", n, blank_run);
                    end
                end else if (prev_sel != sel) begin
                    checks++; errors++;
                    $display("FAIL direct_switch n=%0d got sel %h->%h exp blank between", n, prev_sel, sel);
                end
                blank_run = 0;
            end
            prev_sel = sel;
        end
    endtask

    task automatic test_brightness(input logic [3:0] b);
        int lit_cnt;
        brightness = b; digit_en = 4'hF; values = 16'($urandom);
        sync_frame();
        lit_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL brightness%0d n=%0d got seg=%h sel=%h exp seg=%h sel=%h",
                         b, n, seg, sel, exp_seg, exp_sel);
            end
            if (sel != 4'hF) lit_cnt++;
        end
        checks++;
        if (lit_cnt != 4 * (4 * (int'(b) + 1) - 2)) begin
            errors++;
            $display("FAIL duty_b%0d got %0d lit cycles exp %0d", b, lit_cnt, 4 * (4 * (int'(b) + 1) - 2));
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] old_pat [4];
        logic [6:0] new_pat [4];
        old_pat = '{7'h19, 7'h30, 7'h24, 7'h79};
        new_pat = '{7'h21, 7'h46, 7'h03, 7'h08};
        values = 16'h1234; digit_en = 4'hF; brightness = 4'd15; dp = 4'h0;
        sync_frame();
        for (int k = 0; k < 512; k++) begin
            step();
            if (k == 100) values = 16'hABCD;
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL tear_free n=%0d got seg=%h sel=%h exp seg=%h sel=%h", n, seg, sel, exp_seg, exp_sel);
            end
            if (m_lit) begin
                checks++;
                if (seg !== ((k < 256) ? old_pat[m_idx] : new_pat[m_idx])) begin
                    errors++;
                    $display("FAIL tear_glyph n=%0d digit=%0d got seg=%h exp %h", n, m_idx, seg,
                             (k < 256) ? old_pat[m_idx] : new_pat[m_idx]);
                end
            end
        end
    endtask

    task automatic test_digit_en();
        values = 16'($urandom); digit_en = 4'b0101; dp = 4'b0001; brightness = 4'd15;
        sync_frame();
        for (int k = 0; k < 256; k++) begin
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL digit_en n=%0d got seg=%h dp=%b sel=%h exp seg=%h dp=%b sel=%h",
                         n, seg, seg_dp, sel, exp_seg, exp_dp, exp_sel);
            end
            checks++;
            if (sel[1] !== 1'b1 || sel[3] !== 1'b1) begin
                errors++;
                $display("FAIL disabled_digit n=%0d got sel=%h exp sel[1]=sel[3]=1", n, sel);
            end
            if (m_lit && m_idx == 0) begin
                checks++;
                if (seg_dp !== 1'b0) begin
                    errors++;
                    $display("FAIL dp_digit0 n=%0d got seg_dp=%b exp 0", n, seg_dp);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1024; k++) begin
            if ($urandom_range(49, 0) == 0) begin
                values     = 16'($urandom);
                dp         = 4'($urandom);
                digit_en   = 4'($urandom);
                brightness = 4'($urandom);
            end
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL random n=%0d got seg=%h dp=%b sel=%h tick=%b exp seg=%h dp=%b sel=%h tick=%b",
                         n, seg, seg_dp, sel, frame_tick, exp_seg, exp_dp, exp_sel, exp_tick);
            end
        end
    endtask

    task automatic test_mid_reset();
        values = 16'h1234; digit_en = 4'hF; brightness = 4'd15; dp = 4'hF;
        sync_frame();
        for (int k = 0; k < 100; k++) step();
        checks++;
        if (sel !== 4'hD || seg !== 7'h30) begin
            errors++;
            $display("FAIL pre_reset_lit got seg=%h sel=%h exp seg=30 sel=d", seg, sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({seg, seg_dp, sel, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got seg=%h dp=%b sel=%h tick=%b exp seg=7f dp=1 sel=f tick=0",
                     seg, seg_dp, sel, frame_tick);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        dp = 4'h0;
        for (int k = 0; k < 300; k++) begin
            step();
            checks++;
            if ({seg, seg_dp, sel, frame_tick} !== {exp_seg, exp_dp, exp_sel, exp_tick}) begin
                errors++;
                $display("FAIL post_reset n=%0d got seg=%h dp=%b sel=%h tick=%b exp seg=%h dp=%b sel=%h tick=%b",
                         n, seg, seg_dp, sel, frame_tick, exp_seg, exp_dp, exp_sel, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_blanking();
        test_brightness(4'd3);
        test_brightness(4'd0);
        test_brightness(4'($urandom_range(15, 0)));
        test_tear_free();
        test_digit_en();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
